// File: rtl/or1k_execute_ctrl_pipe.sv
// or1k_execute_ctrl_pipe
// Multi-stage execute control pipeline. Carries the result payload, PC, RF
// writeback info and exception flags down DEPTH stages. Empty stages are
// collapsed, and the last stage can stall until a bus/SPR ack arrives.
// It produces a registered RF write strobe one cycle after an entry retires.
// Optional macro OR1K_EXECUTE_CTRL_PIPE_HAZARD_EN adds a combinational
// destination-register hazard lookup on hit_o. Without it, hit_o is tied to 0.
module or1k_execute_ctrl_pipe #(
    parameter int          DEPTH         = 2,
    parameter int          DATA_WIDTH    = 32,
    parameter int          RF_ADDR_WIDTH = 5,
    parameter int          EXC_WIDTH     = 11,
    parameter logic [31:0] RESET_PC      = 32'h100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [DATA_WIDTH-1:0]          in_data_i,
    input  logic [31:0]                    in_pc_i,
    input  logic                           in_rf_wb_i,
    input  logic [RF_ADDR_WIDTH-1:0]       in_rfd_adr_i,
    input  logic [EXC_WIDTH-1:0]           in_exc_i,
    input  logic                           in_wait_ack_i,
    input  logic                           ack_i,
    input  logic                           out_ready_i,
    output logic                           out_valid_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [31:0]                    out_pc_o,
    output logic [EXC_WIDTH-1:0]           out_exc_o,
    output logic                           retire_o,
    output logic                           wb_en_o,
    output logic [RF_ADDR_WIDTH-1:0]       wb_rfd_adr_o,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_o,
    input  logic [RF_ADDR_WIDTH-1:0]       query_adr_i,
    output logic                           hit_o
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int L     = DEPTH - 1;

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         rf_wb_q;
    logic [DEPTH-1:0]         wait_ack_q;
    logic [DATA_WIDTH-1:0]    data_q    [DEPTH];
    logic [31:0]              pc_q      [DEPTH];
    logic [RF_ADDR_WIDTH-1:0] rfd_adr_q [DEPTH];
    logic [EXC_WIDTH-1:0]     exc_q     [DEPTH];

    logic                     wb_en_q;
    logic [RF_ADDR_WIDTH-1:0] wb_rfd_adr_q;
    logic [OCC_W-1:0]         occ_q;

    logic                     stall_last;
    logic                     retire;
    logic                     accept;
    logic [DEPTH-1:0]         acc;

    logic [DEPTH-1:0]         src_valid;
    logic [DEPTH-1:0]         src_rf_wb;
    logic [DEPTH-1:0]         src_wait_ack;
    logic [DATA_WIDTH-1:0]    src_data    [DEPTH];
    logic [31:0]              src_pc      [DEPTH];
    logic [RF_ADDR_WIDTH-1:0] src_rfd_adr [DEPTH];
    logic [EXC_WIDTH-1:0]     src_exc     [DEPTH];

    // An entry carrying an exception never waits for an ack.
    assign stall_last = valid_q[L] & wait_ack_q[L] & (exc_q[L] == '0) & ~ack_i;
    assign retire     = valid_q[L] & out_ready_i & ~stall_last & ~flush_i;

    // Accept chain: a stage takes new contents when empty or when its entry moves on.
    always_comb begin
        acc    = '0;
        acc[L] = ~valid_q[L] | retire;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            acc[k] = ~valid_q[k] | acc[k+1];
        end
    end

    // Source of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid[0]    = in_valid_i;
        src_rf_wb[0]    = in_rf_wb_i;
        src_wait_ack[0] = in_wait_ack_i;
        src_data[0]     = in_data_i;
        src_pc[0]       = in_pc_i;
        src_rfd_adr[0]  = in_rfd_adr_i;
        src_exc[0]      = in_exc_i;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k]    = valid_q[k-1];
            src_rf_wb[k]    = rf_wb_q[k-1];
            src_wait_ack[k] = wait_ack_q[k-1];
            src_data[k]     = data_q[k-1];
            src_pc[k]       = pc_q[k-1];
            src_rfd_adr[k]  = rfd_adr_q[k-1];
            src_exc[k]      = exc_q[k-1];
        end
    end

    assign in_ready_o = acc[0] & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    // Stage registers: payload fields only change when a valid entry is loaded,
    // so the PC of the last real entry survives bubbles and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rf_wb_q    <= '0;
            wait_ack_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k]    <= '0;
                pc_q[k]      <= RESET_PC;
                rfd_adr_q[k] <= '0;
                exc_q[k]     <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                exc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (acc[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        rf_wb_q[k]    <= src_rf_wb[k];
                        wait_ack_q[k] <= src_wait_ack[k];
                        data_q[k]     <= src_data[k];
                        pc_q[k]       <= src_pc[k];
                        rfd_adr_q[k]  <= src_rfd_adr[k];
                        exc_q[k]      <= src_exc[k];
                    end
                end
            end
        end
    end

    // Registered RF writeback strobe and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q      <= 1'b0;
            wb_rfd_adr_q <= '0;
            occ_q        <= '0;
        end else begin
            wb_en_q      <= retire & rf_wb_q[L] & (exc_q[L] == '0);
            wb_rfd_adr_q <= rfd_adr_q[L];
            if (flush_i) begin
                occ_q <= '0;
            end else begin
                case ({accept, retire})
                    2'b10:   occ_q <= occ_q + OCC_W'(1);
                    2'b01:   occ_q <= occ_q - OCC_W'(1);
                    default: occ_q <= occ_q;
                endcase
            end
        end
    end

    assign out_valid_o  = valid_q[L];
    assign out_data_o   = data_q[L];
    assign out_pc_o     = pc_q[L];
    assign out_exc_o    = exc_q[L] & {EXC_WIDTH{valid_q[L]}};
    assign retire_o     = retire;
    assign wb_en_o      = wb_en_q;
    assign wb_rfd_adr_o = wb_rfd_adr_q;
    assign occupancy_o  = occ_q;

`ifdef OR1K_EXECUTE_CTRL_PIPE_HAZARD_EN
    // Hazard lookup: any clean in-flight entry that will write the queried register.
    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[k] && rf_wb_q[k] && (rfd_adr_q[k] == query_adr_i) && (exc_q[k] == '0)) begin
                hit_o = 1'b1;
            end
        end
    end
`else
    logic unused_query;
    assign unused_query = ^query_adr_i;
    assign hit_o        = 1'b0;
`endif

endmodule

// File: tb/tb_or1k_execute_ctrl_pipe.sv
// Testbench for or1k_execute_ctrl_pipe (DEPTH=2): directed vector table,
// hand-written hazard sequence, then randomized traffic against a queue model.
module tb_or1k_execute_ctrl_pipe;

    localparam int D  = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 11;
`ifdef OR1K_EXECUTE_CTRL_PIPE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i, in_valid_i, in_ready_o;
    logic [DW-1:0] in_data_i;
    logic [31:0]   in_pc_i;
    logic          in_rf_wb_i;
    logic [AW-1:0] in_rfd_adr_i;
    logic [EW-1:0] in_exc_i;
    logic          in_wait_ack_i, ack_i, out_ready_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [31:0]   out_pc_o;
    logic [EW-1:0] out_exc_o;
    logic          retire_o, wb_en_o;
    logic [AW-1:0] wb_rfd_adr_o;
    logic [1:0]    occupancy_o;
    logic [AW-1:0] query_adr_i;
    logic          hit_o;

    or1k_execute_ctrl_pipe #(.DEPTH(D), .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW),
                             .EXC_WIDTH(EW), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_pc_i(in_pc_i), .in_rf_wb_i(in_rf_wb_i), .in_rfd_adr_i(in_rfd_adr_i),
        .in_exc_i(in_exc_i), .in_wait_ack_i(in_wait_ack_i), .ack_i(ack_i),
        .out_ready_i(out_ready_i), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_pc_o(out_pc_o), .out_exc_o(out_exc_o), .retire_o(retire_o),
        .wb_en_o(wb_en_o), .wb_rfd_adr_o(wb_rfd_adr_o), .occupancy_o(occupancy_o),
        .query_adr_i(query_adr_i), .hit_o(hit_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fl, iv;
        logic [31:0] pc;
        logic        rfwb;
        logic [4:0]  rd;
        logic [10:0] exc;
        logic        wa, ack, ordy;
        logic        e_rdy, e_ov;
        logic [31:0] e_pc;
        logic [10:0] e_exc;
        logic        e_ret, e_wb;
        logic [4:0]  e_wrd;
        logic [1:0]  e_occ;
    } vec_t;

    function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic rfwb, logic [4:0] rd,
                                logic [10:0] exc, logic wa, logic ack, logic ordy,
                                logic e_rdy, logic e_ov, logic [31:0] e_pc, logic [10:0] e_exc,
                                logic e_ret, logic e_wb, logic [4:0] e_wrd, logic [1:0] e_occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.rfwb = rfwb; v.rd = rd; v.exc = exc;
        v.wa = wa; v.ack = ack; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_exc = e_exc;
        v.e_ret = e_ret; v.e_wb = e_wb; v.e_wrd = e_wrd; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic drive_idle();
        flush_i = 0; in_valid_i = 0; in_data_i = '0; in_pc_i = '0; in_rf_wb_i = 0;
        in_rfd_adr_i = '0; in_exc_i = '0; in_wait_ack_i = 0; ack_i = 0;
        out_ready_i = 1; query_adr_i = '0;
    endtask

    // Reference model: in-order queue of entries, each tagged with its stage position.
    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        rfwb;
        logic [4:0]  rd;
        logic [10:0] exc;
        logic        wa;
        int          pos;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc, m_data;
    logic        m_wb;
    logic [4:0]  m_wrd;

    vec_t tbl[21];

    initial begin
        int   n;
        bit   f_last, m_stall, m_ret, m_rdy, m_hit;
        bit   mv[D];
        ent_t e;

        // Directed table: inputs | ready, out_valid, out_pc, out_exc, retire, wb_en, wb_rd, occupancy
        tbl[0]  = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,0,32'h100,11'h000,0,0,0,0);
        tbl[1]  = mk(0,1,32'h200,1, 3,11'h000,0,0,1,  1,0,32'h100,11'h000,0,0,0,0);
        tbl[2]  = mk(0,1,32'h204,1, 4,11'h000,0,0,1,  1,0,32'h100,11'h000,0,0,0,1);
        tbl[3]  = mk(0,1,32'h208,1, 5,11'h000,0,0,1,  1,1,32'h200,11'h000,1,0,0,2);
        tbl[4]  = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,1,32'h204,11'h000,1,1,3,2);
        tbl[5]  = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,1,32'h208,11'h000,1,1,4,1);
        tbl[6]  = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,0,32'h208,11'h000,0,1,5,0);
        tbl[7]  = mk(0,1,32'h300,1, 7,11'h000,1,0,1,  1,0,32'h208,11'h000,0,0,0,0);
        tbl[8]  = mk(0,1,32'h304,1, 8,11'h000,0,0,1,  1,0,32'h208,11'h000,0,0,0,1);
        tbl[9]  = mk(0,1,32'h308,1,10,11'h000,0,0,1,  0,1,32'h300,11'h000,0,0,0,2);
        tbl[10] = mk(0,1,32'h308,1,10,11'h000,0,0,1,  0,1,32'h300,11'h000,0,0,0,2);
        tbl[11] = mk(0,1,32'h308,1,10,11'h000,0,0,1,  0,1,32'h300,11'h000,0,0,0,2);
        tbl[12] = mk(0,1,32'h308,1,10,11'h000,0,0,1,  0,1,32'h300,11'h000,0,0,0,2);
        tbl[13] = mk(0,1,32'h308,1,10,11'h000,0,1,1,  1,1,32'h300,11'h000,1,0,0,2);
        tbl[14] = mk(0,0,32'h000,0, 0,11'h000,0,0,0,  0,1,32'h304,11'h000,0,1,7,2);
        tbl[15] = mk(1,1,32'h400,1,11,11'h000,0,1,1,  0,1,32'h304,11'h000,0,0,0,2);
        tbl[16] = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,0,32'h304,11'h000,0,0,0,0);
        tbl[17] = mk(0,1,32'h500,1,12,11'h004,1,0,1,  1,0,32'h304,11'h000,0,0,0,0);
        tbl[18] = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,0,32'h304,11'h000,0,0,0,1);
        tbl[19] = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,1,32'h500,11'h004,1,0,0,1);
        tbl[20] = mk(0,0,32'h000,0, 0,11'h000,0,0,1,  1,0,32'h500,11'h000,0,0,0,0);

        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            rst           = 0;
            flush_i       = tbl[i].fl;
            in_valid_i    = tbl[i].iv;
            in_pc_i       = tbl[i].pc;
            in_data_i     = tbl[i].pc ^ 32'hA5A5_0000;
            in_rf_wb_i    = tbl[i].rfwb;
            in_rfd_adr_i  = tbl[i].rd;
            in_exc_i      = tbl[i].exc;
            in_wait_ack_i = tbl[i].wa;
            ack_i         = tbl[i].ack;
            out_ready_i   = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i),  32'(in_ready_o),  32'(tbl[i].e_rdy));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d out_pc", i),    out_pc_o,         tbl[i].e_pc);
            chk($sformatf("v%0d out_exc", i),   32'(out_exc_o),   32'(tbl[i].e_exc));
            chk($sformatf("v%0d retire", i),    32'(retire_o),    32'(tbl[i].e_ret));
            chk($sformatf("v%0d wb_en", i),     32'(wb_en_o),     32'(tbl[i].e_wb));
            chk($sformatf("v%0d occupancy", i), 32'(occupancy_o), 32'(tbl[i].e_occ));
            if (tbl[i].e_wb)
                chk($sformatf("v%0d wb_rd", i), 32'(wb_rfd_adr_o), 32'(tbl[i].e_wrd));
            if (tbl[i].e_ov)
                chk($sformatf("v%0d out_data", i), out_data_o, tbl[i].e_pc ^ 32'hA5A5_0000);
        end

        // Hazard lookup on an in-flight writer of r9.
        @(posedge clk); #1;
        drive_idle();
        in_valid_i = 1; in_pc_i = 32'h600; in_rf_wb_i = 1; in_rfd_adr_i = 5'd9;
        out_ready_i = 0; query_adr_i = 5'd9;
        @(negedge clk);
        chk("hz_empty", 32'(hit_o), 32'(0));
        @(posedge clk); #1;
        in_valid_i = 0;
        @(negedge clk);
        chk("hz_q9_s0", 32'(hit_o), 32'(HAZ));
        query_adr_i = 5'd8; #1;
        chk("hz_q8_s0", 32'(hit_o), 32'(0));
        @(posedge clk); #1;
        query_adr_i = 5'd9;
        @(negedge clk);
        chk("hz_q9_s1", 32'(hit_o), 32'(HAZ));
        chk("hz_occ", 32'(occupancy_o), 32'(1));

        // Randomized traffic against the queue model.
        @(posedge clk); #1;
        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        q.delete(); m_pc = 32'h100; m_data = '0; m_wb = 0; m_wrd = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 149) == 0);
            flush_i       = ($urandom_range(0, 19) == 0);
            in_valid_i    = ($urandom_range(0, 9) < 7);
            in_pc_i       = $urandom & 32'hFFFF_FFFC;
            in_data_i     = $urandom;
            in_rf_wb_i    = ($urandom_range(0, 9) < 6);
            in_rfd_adr_i  = 5'($urandom_range(0, 7));
            in_exc_i      = ($urandom_range(0, 6) == 0) ? 11'(1 << $urandom_range(0, 10)) : 11'h0;
            in_wait_ack_i = ($urandom_range(0, 9) < 4);
            ack_i         = ($urandom_range(0, 9) < 3);
            out_ready_i   = ($urandom_range(0, 3) != 0);
            query_adr_i   = 5'($urandom_range(0, 7));

            n       = q.size();
            f_last  = (n > 0) && (q[0].pos == D - 1);
            m_stall = f_last && q[0].wa && (q[0].exc == 0) && !ack_i;
            m_ret   = f_last && out_ready_i && !m_stall && !flush_i;
            for (int i = 0; i < D; i++) mv[i] = 0;
            for (int i = 0; i < n; i++) begin
                if (i == 0) mv[i] = (q[0].pos < D - 1) || m_ret;
                else        mv[i] = (q[i].pos + 1 < q[i-1].pos) || mv[i-1];
            end
            m_rdy = !flush_i && ((n == 0) || (q[n-1].pos > 0) || mv[n-1]);
            m_hit = 0;
            foreach (q[i])
                if (q[i].rfwb && q[i].rd == query_adr_i && q[i].exc == 0) m_hit = HAZ;

            @(negedge clk);
            chk("r_in_ready",  32'(in_ready_o),  32'(m_rdy));
            chk("r_out_valid", 32'(out_valid_o), 32'(f_last));
            chk("r_out_pc",    out_pc_o,         m_pc);
            chk("r_out_data",  out_data_o,       f_last ? q[0].data : m_data);
            chk("r_out_exc",   32'(out_exc_o),   f_last ? 32'(q[0].exc) : 32'(0));
            chk("r_retire",    32'(retire_o),    32'(m_ret));
            chk("r_wb_en",     32'(wb_en_o),     32'(m_wb));
            if (m_wb) chk("r_wb_rd", 32'(wb_rfd_adr_o), 32'(m_wrd));
            chk("r_occupancy", 32'(occupancy_o), 32'(n));
            chk("r_hit",       32'(hit_o),       32'(m_hit));

            if (rst) begin
                q.delete(); m_pc = 32'h100; m_data = '0; m_wb = 0;
            end else if (flush_i) begin
                q.delete(); m_wb = 0;
            end else begin
                m_wb = m_ret && q[0].rfwb && (q[0].exc == 0);
                if (m_ret) m_wrd = q[0].rd;
                for (int i = 0; i < n; i++) begin
                    if (mv[i] && !(i == 0 && m_ret)) begin
                        e = q[i];
                        e.pos = e.pos + 1;
                        q[i] = e;
                        if (e.pos == D - 1) begin m_pc = e.pc; m_data = e.data; end
                    end
                end
                if (m_ret) void'(q.pop_front());
                if (in_valid_i && m_rdy) begin
                    e.data = in_data_i; e.pc = in_pc_i; e.rfwb = in_rf_wb_i;
                    e.rd = in_rfd_adr_i; e.exc = in_exc_i; e.wa = in_wait_ack_i; e.pos = 0;
                    q.push_back(e);
                    if (D == 1) begin m_pc = e.pc; m_data = e.data; end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
